cisr_row_len_encoder: RTL

- Producer side of the CISR row-length channel FIFOs.
- Takes a sequential stream of sparse-matrix row lengths, in row order, and writes each length into one per-channel row-length FIFO.
- Channel choice replicates, cycle-abstractly, the accumulator's slot-assignment rule: the lowest-index channel whose remaining-element counter is zero gets the next row.
- Result: row k sent to channel c here is exactly the row the accumulator assigns id k on channel c.

---
 rtl/cisr_row_len_encoder.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/cisr_row_len_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : cisr_row_len_encoder
// Description : Producer side of the CISR row-length channel FIFOs. Accepts
//               a row-ordered stream of sparse-matrix row lengths and writes
//               each one into a per-channel row-length FIFO. The channel is
//               chosen with the accumulator's slot-assignment rule: the
//               lowest-index channel whose shadow remaining-element counter
//               is zero gets the next row. Row k sent to channel c is
//               therefore the row the accumulator assigns id k on channel c.
//
// Ports       :
//   clk                 in   clock, all state on rising edge
//   rst                 in   asynchronous active-high reset
//   start               in   one-cycle pulse, begins a matrix from IDLE/DONE
//   in_row_len          in   next row length
//   in_valid            in   in_row_len is valid
//   in_last             in   in_row_len is the final row of the matrix
//   in_ready            out  row accepted when in_valid && in_ready
//   row_len_fifo_data   out  in_row_len replicated into every channel slot
//   row_len_fifo_full   in   per-channel FIFO full
//   row_len_fifo_write  out  per-channel write strobe (one-hot or zero)
//   rows_dispatched     out  rows accepted since start (wraps)
//   busy                out  state == RUN
//   done                out  state == DONE
//
// Revision    : 1.0 - initial release
// ============================================================================
module cisr_row_len_encoder #(
    parameter int CHANNEL_NUM     = 4,
    parameter int CHANNEL_NUM_LOG = 2,
    parameter int ROW_LEN_SIZE    = 8,
    parameter int ROW_ID_SIZE     = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [ROW_LEN_SIZE-1:0]           in_row_len,
    input  logic                              in_valid,
    input  logic                              in_last,
    output logic                              in_ready,
    output logic [ROW_LEN_SIZE*CHANNEL_NUM-1:0] row_len_fifo_data,
    input  logic [CHANNEL_NUM-1:0]            row_len_fifo_full,
    output logic [CHANNEL_NUM-1:0]            row_len_fifo_write,
    output logic [ROW_ID_SIZE-1:0]            rows_dispatched,
    output logic                              busy,
    output logic                              done
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_next;

    // Shadow copies of the accumulator's remaining-element counters.
    logic [ROW_LEN_SIZE-1:0]    r_counter [CHANNEL_NUM];
    logic [ROW_ID_SIZE-1:0]     r_rows_dispatched;

    logic [CHANNEL_NUM-1:0]     w_is_zero;
    logic                       w_has_zero;
    logic [CHANNEL_NUM_LOG-1:0] w_first_index;
    logic                       w_start;
    logic                       w_accept;
    logic                       w_advance;

    // ------------------------------------------------------------------------
    // Channel selection terms
    // ------------------------------------------------------------------------
    generate
        for (genvar j = 0; j < CHANNEL_NUM; j++) begin : g_zero
            assign w_is_zero[j] = (r_counter[j] == '0);
        end
    endgenerate

    assign w_has_zero = |w_is_zero;

    // Priority encoder: scanning from the top down lets the lowest
    // zero-counter channel overwrite any higher one.
    always_comb begin
        w_first_index = '0;
        for (int j = CHANNEL_NUM - 1; j >= 0; j--) begin
            if (w_is_zero[j]) begin
                w_first_index = CHANNEL_NUM_LOG'(j);
            end
        end
    end

    // start only matters outside RUN; a pulse during RUN is ignored.
    assign w_start   = start && (r_state != c_st_run);
    assign w_accept  = in_valid && in_ready;
    // An advance cycle models one accumulator consume step. It may only occur
    // when every slot holds a row, so counters can never underflow.
    assign w_advance = (r_state == c_st_run) && !w_has_zero;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_next = c_st_run;
                end
            end
            c_st_run: begin
                if (w_accept && in_last) begin
                    w_state_next = c_st_done;
                end
            end
            c_st_done: begin
                if (start) begin
                    w_state_next = c_st_run;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    // Handshake and strobe are combinational against the current full flag,
    // so a zero-length row can re-target the same channel the next cycle.
    always_comb begin
        busy               = 1'b0;
        done               = 1'b0;
        in_ready           = 1'b0;
        row_len_fifo_write = '0;
        case (r_state)
            c_st_run: begin
                busy     = 1'b1;
                in_ready = w_has_zero && !row_len_fifo_full[w_first_index];
                if (in_valid && in_ready) begin
                    row_len_fifo_write = CHANNEL_NUM'(1) << w_first_index;
                end
            end
            c_st_done: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: shadow counters and dispatched-row count
    // ------------------------------------------------------------------------
    // Stall cycles (slot free but no handshake) leave everything untouched:
    // the accumulator does not advance while a slot awaits a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < CHANNEL_NUM; j++) begin
                r_counter[j] <= '0;
            end
            r_rows_dispatched <= '0;
        end else if (w_start) begin
            for (int j = 0; j < CHANNEL_NUM; j++) begin
                r_counter[j] <= '0;
            end
            r_rows_dispatched <= '0;
        end else if (r_state == c_st_run) begin
            if (w_accept) begin
                r_counter[w_first_index] <= in_row_len;
                r_rows_dispatched        <= r_rows_dispatched + ROW_ID_SIZE'(1);
            end else if (w_advance) begin
                for (int j = 0; j < CHANNEL_NUM; j++) begin
                    r_counter[j] <= r_counter[j] - ROW_LEN_SIZE'(1);
                end
            end
        end
    end

    assign rows_dispatched = r_rows_dispatched;

    // ------------------------------------------------------------------------
    // Data fan-out: every slot carries the same length; the strobe picks one.
    // ------------------------------------------------------------------------
    generate
        for (genvar j = 0; j < CHANNEL_NUM; j++) begin : g_data_slot
            assign row_len_fifo_data[j*ROW_LEN_SIZE +: ROW_LEN_SIZE] = in_row_len;
        end
    endgenerate

endmodule
`default_nettype wire
